systemizer_host: RTL and testbench

- Host-side driver for the systemizer's memory and control ports.
- Accepts a matrix as a valid/ready word stream and writes it into systemizer memory, then pulses start and waits for done.
- On success, reads the systemized matrix back and emits it as a valid/ready stream with a last marker.
- Sits between the top-level I/O shim and the systemizer instance.

---
 rtl/systemizer_host.sv | 192 +++++++++++++++++++
 tb/tb_systemizer_host.sv | 383 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/systemizer_host.sv
// Host-side sequencer for the systemizer: streams a matrix into its memory,
// starts it, waits for done and streams the systemized matrix back out.
//
// state  | meaning
// IDLE   | ready for the first word of a new job
// LOAD   | writing incoming words to sequential memory addresses
// START  | one-cycle start pulse to the systemizer
// WAIT   | waiting for the systemizer done pulse
// UNLOAD | reading memory back through a two-entry skid buffer
// FIN    | one-cycle job_done pulse with pass/fail status
module systemizer_host #(
  parameter int N = 4,
  parameter int M = 3,
  parameter int L = 16,
  parameter int K = 24,
  localparam int EW = $clog2(M),
  localparam int W = N * EW,
  localparam int DEPTH = L * K / N,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_data,
  output logic          out_last,
  output logic          job_done,
  output logic          job_fail,
  output logic          busy,
  output logic          sys_start,
  input  logic          sys_done,
  input  logic          sys_fail,
  output logic          sys_wr_en,
  output logic [AW-1:0] sys_wr_addr,
  output logic [W-1:0]  sys_data_in,
  output logic          sys_rd_en,
  output logic [AW-1:0] sys_rd_addr,
  input  logic [W-1:0]  sys_data_out
);

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_START, S_WAIT, S_UNLOAD, S_FIN} state_e;

  state_e        state_q, state_d;
  logic          armed_q;
  logic [AW-1:0] wr_cnt_q, wr_cnt_d;
  logic [AW-1:0] rd_cnt_q, rd_cnt_d;
  logic [AW-1:0] out_cnt_q, out_cnt_d;
  logic          rd_fin_q, rd_fin_d;
  logic          infl_q, infl_d;
  logic          fail_q, fail_d;
  logic [1:0]    buf_cnt_q, buf_cnt_d;
  logic [W-1:0]  buf0_q, buf0_d, buf1_q, buf1_d;
  logic          in_fire, pop;
  logic [1:0]    occ;

  // armed_q keeps in_ready low while reset is applied and for the first edge after
  assign in_ready    = armed_q && (state_q == S_IDLE || state_q == S_LOAD);
  assign in_fire     = in_valid && in_ready;
  assign out_valid   = (buf_cnt_q != 2'd0);
  assign out_data    = buf0_q;
  assign out_last    = out_valid && (out_cnt_q == LAST);
  assign pop         = out_valid && out_ready;
  assign busy        = (state_q != S_IDLE);
  assign job_fail    = fail_q;
  assign sys_wr_addr = wr_cnt_q;
  assign sys_data_in = in_data;
  assign sys_rd_addr = rd_cnt_q;
  assign occ         = buf_cnt_q + {1'b0, infl_q} - {1'b0, pop};

  always_comb begin
    state_d   = state_q;
    wr_cnt_d  = wr_cnt_q;
    rd_cnt_d  = rd_cnt_q;
    out_cnt_d = out_cnt_q;
    rd_fin_d  = rd_fin_q;
    fail_d    = fail_q;
    sys_wr_en = 1'b0;
    sys_start = 1'b0;
    sys_rd_en = 1'b0;
    job_done  = 1'b0;
    case (state_q)
      S_IDLE, S_LOAD: begin
        if (in_fire) begin
          sys_wr_en = 1'b1;
          fail_d    = 1'b0;
          if (wr_cnt_q == LAST) begin
            wr_cnt_d = '0;
            state_d  = S_START;
          end else begin
            wr_cnt_d = wr_cnt_q + 1'b1;
            state_d  = S_LOAD;
          end
        end
      end
      S_START: begin
        sys_start = 1'b1;
        state_d   = S_WAIT;
      end
      S_WAIT: begin
        if (sys_done) begin
          if (sys_fail) begin
            fail_d  = 1'b1;
            state_d = S_FIN;
          end else begin
            state_d = S_UNLOAD;
          end
        end
      end
      S_UNLOAD: begin
        // credit counts buffered words plus the read in flight, after this cycle's pop
        if (!rd_fin_q && occ < 2'd2) begin
          sys_rd_en = 1'b1;
          if (rd_cnt_q == LAST) rd_fin_d = 1'b1;
          else                  rd_cnt_d = rd_cnt_q + 1'b1;
        end
        if (pop) begin
          if (out_cnt_q == LAST) state_d   = S_FIN;
          else                   out_cnt_d = out_cnt_q + 1'b1;
        end
      end
      S_FIN: begin
        job_done  = 1'b1;
        state_d   = S_IDLE;
        rd_cnt_d  = '0;
        rd_fin_d  = 1'b0;
        out_cnt_d = '0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    infl_d    = sys_rd_en;
    buf0_d    = buf0_q;
    buf1_d    = buf1_q;
    buf_cnt_d = buf_cnt_q;
    case ({pop, infl_q})
      2'b01: begin
        if (buf_cnt_q == 2'd0) buf0_d = sys_data_out;
        else                   buf1_d = sys_data_out;
        buf_cnt_d = buf_cnt_q + 2'd1;
      end
      2'b10: begin
        buf0_d    = buf1_q;
        buf_cnt_d = buf_cnt_q - 2'd1;
      end
      2'b11: begin
        if (buf_cnt_q == 2'd1) begin
          buf0_d = sys_data_out;
        end else begin
          buf0_d = buf1_q;
          buf1_d = sys_data_out;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      armed_q   <= 1'b0;
      wr_cnt_q  <= '0;
      rd_cnt_q  <= '0;
      out_cnt_q <= '0;
      rd_fin_q  <= 1'b0;
      infl_q    <= 1'b0;
      fail_q    <= 1'b0;
      buf_cnt_q <= 2'd0;
      buf0_q    <= '0;
      buf1_q    <= '0;
    end else begin
      state_q   <= state_d;
      armed_q   <= 1'b1;
      wr_cnt_q  <= wr_cnt_d;
      rd_cnt_q  <= rd_cnt_d;
      out_cnt_q <= out_cnt_d;
      rd_fin_q  <= rd_fin_d;
      infl_q    <= infl_d;
      fail_q    <= fail_d;
      buf_cnt_q <= buf_cnt_d;
      buf0_q    <= buf0_d;
      buf1_q    <= buf1_d;
    end
  end

endmodule

// File: tb/tb_systemizer_host.sv
// Self-checking bench for systemizer_host: memory/systemizer model, output
// scoreboard, and one task per scenario.
module tb_systemizer_host;
  localparam int DEPTH = 96;
  localparam int W = 8;
  localparam int AW = 7;
  localparam int SD_LAT = 20;
  localparam int BUDGET = 2000;

  logic clk = 1'b0, rst = 1'b1;
  logic in_valid = 1'b0, in_ready;
  logic [W-1:0] in_data = '0;
  logic out_valid, out_ready = 1'b0, out_last;
  logic [W-1:0] out_data;
  logic job_done, job_fail, busy, sys_start;
  logic sys_done = 1'b0, sys_fail = 1'b0;
  logic sys_wr_en, sys_rd_en;
  logic [AW-1:0] sys_wr_addr, sys_rd_addr;
  logic [W-1:0] sys_data_in, sys_data_out = '0;

  int n_tests = 0, n_fail = 0, cyc = 0;
  logic [W-1:0] mem [DEPTH];
  logic [W-1:0] sb_q[$], wr_q[$];
  bit fail_mode = 1'b0;
  int out_mode = 0, spur_cnt = 0, spur_seen = 0;
  int wr_seen = 0, rd_seen = 0, pop_cnt = 0, starts = 0;
  int first_wr_cyc = 0, last_wr_cyc = 0, sd_cyc = 0;
  int stall_left = 0;
  bit stall_done = 1'b0;

  systemizer_host dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .job_done(job_done), .job_fail(job_fail), .busy(busy),
    .sys_start(sys_start), .sys_done(sys_done), .sys_fail(sys_fail),
    .sys_wr_en(sys_wr_en), .sys_wr_addr(sys_wr_addr), .sys_data_in(sys_data_in),
    .sys_rd_en(sys_rd_en), .sys_rd_addr(sys_rd_addr), .sys_data_out(sys_data_out)
  );

  always #5 clk = ~clk;

  // memory: writes land at the edge, reads return one cycle after sys_rd_en
  initial begin : mem_model
    bit pend;
    logic [AW-1:0] pa;
    forever begin
      @(negedge clk);
      if (sys_wr_en) mem[sys_wr_addr] = sys_data_in;
      if (sys_done && !sys_fail) for (int i = 0; i < DEPTH; i++) mem[i] = mem[i] ^ 8'hA5;
      pend = sys_rd_en;
      pa = sys_rd_addr;
      @(posedge clk); #1;
      sys_data_out = pend ? mem[pa] : 8'h00;
    end
  end

  initial begin : sys_model
    forever begin
      @(negedge clk);
      if (spur_cnt != spur_seen) begin
        spur_seen = spur_cnt;
        @(posedge clk); #1; sys_done = 1'b1; sys_fail = 1'b1;
        @(posedge clk); #1; sys_done = 1'b0; sys_fail = 1'b0;
      end else if (sys_start && rst) begin
        repeat (SD_LAT) @(posedge clk);
        #1; sys_done = 1'b1; sys_fail = fail_mode;
        @(posedge clk); #1; sys_done = 1'b0; sys_fail = 1'b0;
      end
    end
  end

  initial begin : ready_drv
    forever begin
      @(posedge clk); #1;
      if (out_mode == 0) begin
        out_ready = 1'b1; stall_done = 1'b0; stall_left = 0;
      end else if (stall_left > 0) begin
        out_ready = 1'b0; stall_left--;
      end else if (pop_cnt == 40 && !stall_done) begin
        stall_done = 1'b1; stall_left = 9; out_ready = 1'b0;
      end else begin
        out_ready = ~out_ready;
      end
    end
  end

  initial begin : monitor
    logic [W-1:0] exp_d, hold_data;
    bit hold;
    hold = 1'b0;
    hold_data = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst) begin
        wr_seen = 0; rd_seen = 0; pop_cnt = 0; starts = 0; hold = 1'b0;
      end else begin
        if (sys_wr_en) begin
          n_tests++;
          if (wr_seen >= DEPTH || wr_q.size() == 0) begin
            n_fail++;
            $display("FAIL wr_unexpected: addr=%0d data=%0h, no write expected", sys_wr_addr, sys_data_in);
          end else begin
            exp_d = wr_q.pop_front();
            if (sys_wr_addr !== AW'(wr_seen) || sys_data_in !== exp_d) begin
              n_fail++;
              $display("FAIL wr_seq: addr=%0d data=%0h, expected addr=%0d data=%0h", sys_wr_addr, sys_data_in, wr_seen, exp_d);
            end
          end
          if (wr_seen == 0) first_wr_cyc = cyc;
          wr_seen++;
          last_wr_cyc = cyc;
        end
        if (sys_start) begin
          n_tests++;
          starts++;
          if (wr_seen != DEPTH || last_wr_cyc != cyc - 1 || starts != 1) begin
            n_fail++;
            $display("FAIL start_timing: writes=%0d gap=%0d starts=%0d, expected %0d/1/1", wr_seen, cyc - last_wr_cyc, starts, DEPTH);
          end
        end
        if (sys_rd_en) begin
          n_tests++;
          if (fail_mode || sys_rd_addr !== AW'(rd_seen)) begin
            n_fail++;
            $display("FAIL rd_addr: addr=%0d fail_job=%0d, expected addr=%0d and no read on fail", sys_rd_addr, fail_mode, rd_seen);
          end
          rd_seen++;
        end
        if (hold) begin
          n_tests++;
          if (out_valid !== 1'b1 || out_data !== hold_data) begin
            n_fail++;
            $display("FAIL stall_hold: valid=%0b data=%0h, expected valid=1 data=%0h", out_valid, out_data, hold_data);
          end
        end
        if (out_valid && out_ready) begin
          n_tests++;
          if (sb_q.size() == 0) begin
            n_fail++;
            $display("FAIL out_extra: data=%0h, scoreboard empty", out_data);
          end else begin
            exp_d = sb_q.pop_front();
            if (out_data !== exp_d || out_last !== (pop_cnt == DEPTH - 1)) begin
              n_fail++;
              $display("FAIL out_word %0d: data=%0h last=%0b, expected data=%0h last=%0b", pop_cnt, out_data, out_last, exp_d, pop_cnt == DEPTH - 1);
            end
          end
          pop_cnt++;
        end else if (out_valid) begin
          n_tests++;
          if (out_last !== (pop_cnt == DEPTH - 1)) begin
            n_fail++;
            $display("FAIL out_last_stall: last=%0b at word %0d", out_last, pop_cnt);
          end
        end
        if (sys_rd_en) begin
          n_tests++;
          if (rd_seen - pop_cnt > 2) begin
            n_fail++;
            $display("FAIL credit: outstanding+buffered=%0d, limit 2", rd_seen - pop_cnt);
          end
        end
        hold = out_valid && !out_ready;
        hold_data = out_data;
        if (sys_done) sd_cyc = cyc;
        if (job_done) begin
          n_tests++;
          if (job_fail !== fail_mode || starts != 1 || pop_cnt != (fail_mode ? 0 : DEPTH) ||
              (fail_mode && cyc != sd_cyc + 1)) begin
            n_fail++;
            $display("FAIL job_end: fail=%0b starts=%0d words=%0d done_lag=%0d, expected fail=%0b starts=1 words=%0d",
                     job_fail, starts, pop_cnt, cyc - sd_cyc, fail_mode, fail_mode ? 0 : DEPTH);
          end
          wr_seen = 0; rd_seen = 0; pop_cnt = 0; starts = 0;
        end
      end
    end
  end

  task automatic load_job(input bit gaps, input bit keep, input bit spur, input logic [W-1:0] seed);
    int idx = 0, guard = 0;
    logic [W-1:0] d;
    while (idx < DEPTH && guard < BUDGET) begin
      @(posedge clk); #1;
      guard++;
      in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      d = W'(idx) ^ seed;
      in_data = d;
      if (in_valid && in_ready) begin
        wr_q.push_back(d);
        sb_q.push_back(d ^ 8'hA5);
        idx++;
        if (spur && idx == 11) spur_cnt++;
      end
    end
    @(posedge clk); #1;
    in_valid = keep;
    in_data = 8'hEE;
    n_tests++;
    if (idx != DEPTH) begin
      n_fail++;
      $display("FAIL load_timeout: accepted=%0d, expected %0d", idx, DEPTH);
    end
  endtask

  task automatic wait_job(output bit got);
    got = 1'b0;
    for (int c = 0; c < BUDGET && !got; c++) begin
      @(negedge clk);
      if (job_done) got = 1'b1;
    end
  endtask

  task automatic test_reset();
    #1 rst = 1'b0;
    #1;
    n_tests++;
    if ({in_ready, out_valid, out_last, job_done, job_fail, busy, sys_start, sys_wr_en, sys_rd_en} !== 9'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %09b, expected 000000000", {in_ready, out_valid, out_last, job_done, job_fail, busy, sys_start, sys_wr_en, sys_rd_en});
    end
    n_tests++;
    if (sys_wr_addr !== '0 || sys_rd_addr !== '0) begin
      n_fail++;
      $display("FAIL reset_addr: wr=%0d rd=%0d, expected 0/0", sys_wr_addr, sys_rd_addr);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_tests++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_after_reset: in_ready=%0b busy=%0b, expected 1/0", in_ready, busy);
    end
  endtask

  task automatic test_full_job();
    bit got;
    fail_mode = 1'b0;
    out_mode = 0;
    load_job(1'b0, 1'b0, 1'b0, 8'h00);
    n_tests++;
    if (last_wr_cyc - first_wr_cyc != DEPTH - 1) begin
      n_fail++;
      $display("FAIL write_span: %0d cycles, expected %0d consecutive", last_wr_cyc - first_wr_cyc + 1, DEPTH);
    end
    wait_job(got);
    n_tests++;
    if (!got || job_fail !== 1'b0) begin
      n_fail++;
      $display("FAIL full_done: done=%0b fail=%0b, expected 1/0", got, job_fail);
    end
    @(negedge clk);
    n_tests++;
    if (busy !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL full_idle: busy=%0b in_ready=%0b, expected 0/1", busy, in_ready);
    end
  endtask

  task automatic test_backpressure();
    bit got;
    out_mode = 1;
    load_job(1'b0, 1'b0, 1'b0, 8'h3C);
    wait_job(got);
    n_tests++;
    if (!got || job_fail !== 1'b0 || sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL bp_done: done=%0b fail=%0b left=%0d, expected 1/0/0", got, job_fail, sb_q.size());
    end
    out_mode = 0;
  endtask

  task automatic test_load_gaps();
    bit got;
    load_job(1'b1, 1'b1, 1'b0, 8'hC3);
    @(negedge clk);
    n_tests++;
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL gaps_ready: in_ready=%0b after last word, expected 0", in_ready);
    end
    wait_job(got);
    in_valid = 1'b0;
    n_tests++;
    if (!got || job_fail !== 1'b0) begin
      n_fail++;
      $display("FAIL gaps_done: done=%0b fail=%0b, expected 1/0", got, job_fail);
    end
  endtask

  task automatic test_fail();
    bit got;
    fail_mode = 1'b1;
    load_job(1'b0, 1'b0, 1'b0, 8'h5A);
    wait_job(got);
    n_tests++;
    if (!got || job_fail !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL fail_done: done=%0b fail=%0b out_valid=%0b, expected 1/1/0", got, job_fail, out_valid);
    end
    sb_q.delete();
    @(negedge clk);
    fail_mode = 1'b0;
    n_tests++;
    if (busy !== 1'b0 || job_fail !== 1'b1) begin
      n_fail++;
      $display("FAIL fail_idle: busy=%0b fail=%0b, expected 0/1", busy, job_fail);
    end
  endtask

  task automatic test_spurious_done();
    bit got;
    load_job(1'b0, 1'b0, 1'b1, 8'h81);
    n_tests++;
    if (job_fail !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL spur_load: fail=%0b busy=%0b, expected 0/1", job_fail, busy);
    end
    wait_job(got);
    n_tests++;
    if (!got || job_fail !== 1'b0) begin
      n_fail++;
      $display("FAIL spur_done: done=%0b fail=%0b, expected 1/0", got, job_fail);
    end
  endtask

  task automatic test_reset_unload();
    bit got;
    int c = 0;
    load_job(1'b0, 1'b0, 1'b0, 8'h77);
    while (pop_cnt < 50 && c < BUDGET) begin
      @(negedge clk);
      c++;
    end
    n_tests++;
    if (pop_cnt < 50) begin
      n_fail++;
      $display("FAIL unload_timeout: words=%0d, expected 50", pop_cnt);
    end
    #1 rst = 1'b0;
    #1;
    n_tests++;
    if ({in_ready, out_valid, out_last, job_done, job_fail, busy, sys_start, sys_wr_en, sys_rd_en} !== 9'b0 ||
        sys_wr_addr !== '0 || sys_rd_addr !== '0) begin
      n_fail++;
      $display("FAIL async_reset: ctrl=%09b wr=%0d rd=%0d, expected all 0", {in_ready, out_valid, out_last, job_done, job_fail, busy, sys_start, sys_wr_en, sys_rd_en}, sys_wr_addr, sys_rd_addr);
    end
    sb_q.delete();
    wr_q.delete();
    repeat (3) @(negedge clk);
    rst = 1'b1;
    load_job(1'b0, 1'b0, 1'b0, 8'h99);
    wait_job(got);
    n_tests++;
    if (!got || job_fail !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset_job: done=%0b fail=%0b, expected 1/0", got, job_fail);
    end
  endtask

  initial begin
    test_reset();
    test_full_job();
    test_backpressure();
    test_load_gaps();
    test_fail();
    test_spurious_done();
    test_reset_unload();
    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
